// File: rtl/dmem_pkg.sv
// dmem_pkg: FSM state encodings and requester port indices for dmem_port_arbiter
package dmem_pkg;
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_CLEAR   = 2'd3;
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter, one-hot grant, pointer advances on each accepted grant
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);
  logic last_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) last_q <= 1'b1;
    else if (advance) last_q <= grant[1];
  assign grant = &req ? (last_q ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: round-robin CPU/debug access to single-port DataMemory with registered read data and a full-memory clear sweep
module dmem_port_arbiter
  import dmem_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 32,
  parameter int                DEPTH     = 256,
  parameter logic [DATA_W-1:0] CLR_VALUE = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              REQ0,
  input  logic              REQ1,
  input  logic              WE0,
  input  logic              WE1,
  input  logic [ADDR_W-1:0] ADDR0,
  input  logic [ADDR_W-1:0] ADDR1,
  input  logic [DATA_W-1:0] WDATA0,
  input  logic [DATA_W-1:0] WDATA1,
  output logic              GNT0,
  output logic              GNT1,
  output logic              RVALID0,
  output logic              RVALID1,
  output logic [DATA_W-1:0] RDATA,
  input  logic              CLR_START,
  output logic              BUSY,
  output logic              CLR_DONE,
  output logic              WR,
  output logic [ADDR_W-1:0] ADDRESS,
  output logic [DATA_W-1:0] BIN,
  input  logic [DATA_W-1:0] DATAOUT
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              flag_q, flag_d, win_q, win_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] bin_q, bin_d, rdata_q, rdata_d;
  logic              wr_q, wr_d, done_q, done_d;
  logic [1:0]        gnt_q, gnt_d, rvalid_q, rvalid_d, req, grant;
  logic              idle_req, last_clr;
  assign req      = {REQ1, REQ0};
  assign idle_req = state_q == S_IDLE && !flag_q && |req;
  assign last_clr = cnt_q == CNT_W'(DEPTH);
  rr_arbiter2 u_rr (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .advance (idle_req),
    .grant   (grant)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      flag_q   <= 1'b0;
      win_q    <= PORT_CPU;
      addr_q   <= '0;
      bin_q    <= '0;
      rdata_q  <= '0;
      wr_q     <= 1'b0;
      done_q   <= 1'b0;
      gnt_q    <= '0;
      rvalid_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      flag_q   <= flag_d;
      win_q    <= win_d;
      addr_q   <= addr_d;
      bin_q    <= bin_d;
      rdata_q  <= rdata_d;
      wr_q     <= wr_d;
      done_q   <= done_d;
      gnt_q    <= gnt_d;
      rvalid_q <= rvalid_d;
    end
  // cnt_q runs one ahead of the address being written, so reaching DEPTH marks the final word
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    flag_d  = flag_q | (CLR_START && state_q != S_CLEAR);
    case (state_q)
      S_IDLE:
        if (flag_q) begin
          state_d = S_CLEAR;
          cnt_d   = CNT_W'(1);
        end else if (|req) begin
          state_d = S_ISSUE;
          win_d   = grant[1];
        end
      S_ISSUE:   state_d = wr_q ? S_IDLE : S_CAPTURE;
      S_CAPTURE: state_d = S_IDLE;
      default:
        if (last_clr) begin
          state_d = S_IDLE;
          flag_d  = 1'b0;
        end else cnt_d = cnt_q + 1'b1;
    endcase
  end
  always_comb begin
    addr_d   = addr_q;
    bin_d    = bin_q;
    rdata_d  = rdata_q;
    wr_d     = 1'b0;
    gnt_d    = '0;
    rvalid_d = '0;
    done_d   = 1'b0;
    if (state_q == S_IDLE && flag_q) begin
      addr_d = '0;
      bin_d  = CLR_VALUE;
      wr_d   = 1'b1;
    end else if (idle_req) begin
      gnt_d  = grant;
      addr_d = grant[1] ? ADDR1 : ADDR0;
      bin_d  = grant[1] ? WDATA1 : WDATA0;
      wr_d   = grant[1] ? WE1 : WE0;
    end else if (state_q == S_ISSUE && !wr_q) begin
      rdata_d  = DATAOUT;
      rvalid_d = win_q == PORT_DBG ? 2'b10 : 2'b01;
    end else if (state_q == S_CLEAR) begin
      wr_d   = !last_clr;
      done_d = last_clr;
      addr_d = last_clr ? addr_q : ADDR_W'(cnt_q);
    end
  end
  assign GNT0     = gnt_q[0];
  assign GNT1     = gnt_q[1];
  assign RVALID0  = rvalid_q[0];
  assign RVALID1  = rvalid_q[1];
  assign RDATA    = rdata_q;
  assign BUSY     = state_q != S_IDLE;
  assign CLR_DONE = done_q;
  assign WR       = wr_q;
  assign ADDRESS  = addr_q;
  assign BIN      = bin_q;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed scoreboard bench for dmem_port_arbiter with a behavioural DataMemory
module tb_dmem_port_arbiter;
  logic        clk = 1'b0, reset = 1'b0;
  logic        REQ0, REQ1, WE0, WE1, CLR_START;
  logic [31:0] ADDR0, ADDR1, WDATA0, WDATA1;
  logic        GNT0, GNT1, RVALID0, RVALID1, BUSY, CLR_DONE, WR;
  logic [31:0] RDATA, ADDRESS, BIN, DATAOUT;
  logic [31:0] mem [256];
  logic [31:0] exp_mem [256];
  typedef struct {logic port; logic [31:0] data;} exp_t;
  exp_t sb[$];
  int checks = 0, failures = 0;
  int n, k, sweep;
  logic done_seen;
  dmem_port_arbiter dut (
    .clk(clk), .reset(reset), .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1),
    .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
    .GNT0(GNT0), .GNT1(GNT1), .RVALID0(RVALID0), .RVALID1(RVALID1), .RDATA(RDATA),
    .CLR_START(CLR_START), .BUSY(BUSY), .CLR_DONE(CLR_DONE), .WR(WR),
    .ADDRESS(ADDRESS), .BIN(BIN), .DATAOUT(DATAOUT)
  );
  always #5 clk = ~clk;
  assign DATAOUT = mem[ADDRESS[7:0]];
  always @(posedge clk) if (WR) mem[ADDRESS[7:0]] <= BIN;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk)
    if (!reset && (RVALID0 || RVALID1)) begin
      checks++;
      assert (sb.size() != 0) else begin
        failures++;
        $error("FAIL rvalid_unexpected observed=%b%b expected=none", RVALID1, RVALID0);
      end
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("rvalid_port", 64'({RVALID1, RVALID0}), 64'(e.port ? 2'b10 : 2'b01));
        chk("rdata", 64'(RDATA), 64'(e.data));
      end
    end
  task automatic wait_gnt(input logic p, input int max, output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!(p ? GNT1 : GNT0) && cnt < max);
    chk("gnt_seen", 64'(p ? GNT1 : GNT0), 64'(1));
    chk("gnt_other", 64'(p ? GNT0 : GNT1), 64'(0));
  endtask
  task automatic access(input logic p, input logic we, input logic [31:0] a, input logic [31:0] d, output int lat);
    @(posedge clk); #1;
    if (p) begin REQ1 = 1'b1; WE1 = we; ADDR1 = a; WDATA1 = d; end
    else begin REQ0 = 1'b1; WE0 = we; ADDR0 = a; WDATA0 = d; end
    wait_gnt(p, 600, lat);
    chk("issue_wr", 64'(WR), 64'(we));
    chk("issue_addr", 64'(ADDRESS), 64'(a));
    if (we) begin
      chk("issue_bin", 64'(BIN), 64'(d));
      exp_mem[a[7:0]] = d;
    end else sb.push_back('{p, exp_mem[a[7:0]]});
    @(posedge clk); #1;
    if (p) REQ1 = 1'b0; else REQ0 = 1'b0;
    @(negedge clk);
    chk("wr_one_cycle", 64'(WR), 64'(0));
    if (!we) chk("rvalid_latency", 64'(p ? RVALID1 : RVALID0), 64'(1));
  endtask
  task automatic pulse_clear();
    @(posedge clk); #1 CLR_START = 1'b1;
    @(posedge clk); #1 CLR_START = 1'b0;
  endtask
  initial begin
    {REQ0, REQ1, WE0, WE1, CLR_START} = '0;
    {ADDR0, ADDR1, WDATA0, WDATA1} = '0;
    #2 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", 64'({WR, BUSY, CLR_DONE, GNT1, GNT0, RVALID1, RVALID0}), 64'(0));
    chk("reset_addr", 64'(ADDRESS), 64'(0));
    chk("reset_bin", 64'(BIN), 64'(0));
    chk("reset_rdata", 64'(RDATA), 64'(0));
    @(negedge clk) reset = 1'b0;
    access(1'b0, 1'b1, 32'd5, 32'hDEADBEEF, n);
    chk("write_latency", 64'(n), 64'(2));
    access(1'b0, 1'b0, 32'd5, 32'h0, n);
    chk("read_latency", 64'(n), 64'(2));
    access(1'b0, 1'b1, 32'd1, 32'h1111_0001, n);
    access(1'b1, 1'b1, 32'd2, 32'h2222_0002, n);
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    REQ0 = 1'b1; WE0 = 1'b0; ADDR0 = 32'd1;
    REQ1 = 1'b1; WE1 = 1'b0; ADDR1 = 32'd2;
    k = 0; n = 0;
    while (k < 4 && n < 40) begin
      @(negedge clk);
      n++;
      if (GNT0 || GNT1) begin
        chk("rr_order", 64'({GNT1, GNT0}), 64'(k[0] ? 2'b10 : 2'b01));
        sb.push_back('{k[0], k[0] ? exp_mem[2] : exp_mem[1]});
        k++;
      end
    end
    chk("rr_grants", 64'(k), 64'(4));
    @(posedge clk); #1 REQ0 = 1'b0; REQ1 = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 256; i++) access(1'b1, 1'b1, 32'(i), 32'hFFFFFFFF, n);
    pulse_clear();
    n = 0;
    do begin @(negedge clk); n++; end while (!WR && n < 10);
    for (int i = 0; i < 256; i++) begin
      if (i > 0) @(negedge clk);
      chk("clr_addr", 64'(ADDRESS), 64'(i));
      chk("clr_wr_busy", 64'({WR, BUSY}), 64'(2'b11));
      chk("clr_bin", 64'(BIN), 64'(0));
    end
    @(negedge clk);
    chk("clr_done", 64'({CLR_DONE, WR}), 64'(2'b10));
    @(negedge clk);
    chk("clr_done_pulse", 64'(CLR_DONE), 64'(0));
    for (int i = 0; i < 256; i++) exp_mem[i] = 32'h0;
    access(1'b0, 1'b0, 32'd0, 32'h0, n);
    access(1'b0, 1'b0, 32'd128, 32'h0, n);
    access(1'b0, 1'b0, 32'd255, 32'h0, n);
    access(1'b1, 1'b1, 32'd7, 32'hA5A5_0007, n);
    @(posedge clk); #1 REQ1 = 1'b1; WE1 = 1'b0; ADDR1 = 32'd7;
    wait_gnt(1'b1, 10, n);
    sb.push_back('{1'b1, exp_mem[7]});
    @(posedge clk); #1 CLR_START = 1'b1; REQ1 = 1'b0;
    @(negedge clk);
    chk("rd_before_clr", 64'(RVALID1), 64'(1));
    chk("clr_not_started", 64'(WR), 64'(0));
    @(posedge clk); #1 CLR_START = 1'b0; REQ0 = 1'b1; WE0 = 1'b0; ADDR0 = 32'd7;
    for (int i = 0; i < 256; i++) exp_mem[i] = 32'h0;
    done_seen = 1'b0; sweep = 0; n = 0;
    while (!GNT0 && n < 600) begin
      @(negedge clk);
      n++;
      if (WR) sweep++;
      if (CLR_DONE) done_seen = 1'b1;
    end
    chk("gnt0_after_clear", 64'(GNT0), 64'(1));
    chk("gnt_after_done", 64'(done_seen), 64'(1));
    chk("sweep_len", 64'(sweep), 64'(256));
    sb.push_back('{1'b0, exp_mem[7]});
    @(posedge clk); #1 REQ0 = 1'b0;
    @(negedge clk);
    chk("rd_after_clr", 64'(RVALID0), 64'(1));
    pulse_clear();
    n = 0;
    do begin @(negedge clk); n++; end while (!(WR && ADDRESS == 32'd100) && n < 400);
    chk("clr_at_100", 64'(ADDRESS), 64'(100));
    reset = 1'b1;
    #1;
    chk("rst_abort", 64'({WR, BUSY, CLR_DONE}), 64'(0));
    @(negedge clk) reset = 1'b0;
    done_seen = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (CLR_DONE) done_seen = 1'b1;
    end
    chk("no_done_after_rst", 64'(done_seen), 64'(0));
    chk("idle_after_rst", 64'({BUSY, WR}), 64'(0));
    pulse_clear();
    n = 0;
    do begin @(negedge clk); n++; end while (!WR && n < 10);
    chk("restart_addr", 64'({WR, ADDRESS}), 64'({1'b1, 32'd0}));
    n = 0;
    do begin @(negedge clk); n++; end while (!CLR_DONE && n < 300);
    chk("restart_done", 64'(CLR_DONE), 64'(1));
    chk("restart_len", 64'(n), 64'(256));
    @(posedge clk); #1 REQ1 = 1'b1; WE1 = 1'b1; ADDR1 = 32'd0; WDATA1 = 32'd0;
    for (int i = 0; i < 6; i++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!GNT1 && n < 10);
      chk("b2b_gnt", 64'(GNT1), 64'(1));
      chk("b2b_gap", 64'(n), 64'(2));
      chk("b2b_addr", 64'(ADDRESS), 64'(i));
      chk("b2b_bin", 64'(BIN), 64'(i));
      chk("b2b_wr", 64'(WR), 64'(1));
      chk("b2b_no_rvalid", 64'({RVALID1, RVALID0}), 64'(0));
      exp_mem[8'(i)] = 32'(i);
      @(posedge clk); #1;
      if (i == 5) REQ1 = 1'b0;
      else begin ADDR1 = 32'(i + 1); WDATA1 = 32'(i + 1); end
    end
    @(negedge clk);
    chk("b2b_wr_drop", 64'(WR), 64'(0));
    access(1'b0, 1'b0, 32'd3, 32'h0, n);
    access(1'b0, 1'b0, 32'd5, 32'h0, n);
    repeat (3) @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
